// File: rtl/vlsu_cam_prio_if.sv
// vlsu_cam_prio_if: write/clear/search bundle between LSQ allocation, disambiguation and the CAM
interface vlsu_cam_prio_if #(
  parameter int WIDTH = 50,
  parameter int DEPTH = 32,
  parameter int WRITE = 2,
  parameter int READ = 3,
  parameter int ADDRESS = $clog2(DEPTH)
);
  logic [ADDRESS-1:0] head_i;
  logic [READ-1:0][DEPTH-1:0] enable_i;
  logic [WRITE-1:0] write_i;
  logic [WRITE-1:0][ADDRESS-1:0] write_addr_i;
  logic [WRITE-1:0][WIDTH-1:0] write_data_i;
  logic clear_i;
  logic [ADDRESS-1:0] clear_addr_i;
  logic [READ-1:0] read_i;
  logic [READ-1:0][WIDTH-1:0] read_data_i;
  logic [READ-1:0][WIDTH-1:0] read_mask_i;
  logic [READ-1:0] match_o;
  logic [READ-1:0][ADDRESS-1:0] match_data_o;
  logic [READ-1:0] multi_match_o;
  logic [$clog2(DEPTH+1)-1:0] count_o;
  logic full_o;
  modport master (
    output head_i, enable_i, write_i, write_addr_i, write_data_i, clear_i, clear_addr_i,
           read_i, read_data_i, read_mask_i,
    input match_o, match_data_o, multi_match_o, count_o, full_o
  );
  modport slave (
    input head_i, enable_i, write_i, write_addr_i, write_data_i, clear_i, clear_addr_i,
          read_i, read_data_i, read_mask_i,
    output match_o, match_data_o, multi_match_o, count_o, full_o
  );
endinterface

// File: rtl/vlsu_cam_prio.sv
// vlsu_cam_prio: multi-port masked CAM with valid bits, head-relative priority and registered matches
module vlsu_cam_prio #(
  parameter int WIDTH = 50,
  parameter int DEPTH = 32,
  parameter int WRITE = 2,
  parameter int READ = 3,
  parameter int ADDRESS = $clog2(DEPTH),
  parameter logic [READ-1:0] PRIORITY_EN = 3'b111,
  parameter bit BYPASS = 1'b1
) (
  input logic clk,
  input logic rst_n,
  vlsu_cam_prio_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d, srch_mem;
  logic [DEPTH-1:0] valid_q, valid_d, srch_valid;
  logic [CW-1:0] count_q, count_d;
  logic [READ-1:0] match_q, match_d, multi_q, multi_d;
  logic [READ-1:0][ADDRESS-1:0] idx_q, idx_d;
  logic [READ-1:0][DEPTH-1:0] hit;
  always_comb begin
    mem_d = mem_q;
    valid_d = valid_q;
    if (bus.clear_i) valid_d[bus.clear_addr_i] = 1'b0;
    for (int w = 0; w < WRITE; w++)
      if (bus.write_i[w]) begin
        mem_d[bus.write_addr_i[w]] = bus.write_data_i[w];
        valid_d[bus.write_addr_i[w]] = 1'b1;
      end
    count_d = count_q;
    for (int e = 0; e < DEPTH; e++)
      count_d = count_d + CW'(valid_d[e] & ~valid_q[e]) - CW'(valid_q[e] & ~valid_d[e]);
  end
  assign srch_mem = BYPASS ? mem_d : mem_q;
  assign srch_valid = BYPASS ? valid_d : valid_q;
  always_comb begin
    hit = '0;
    match_d = '0;
    multi_d = '0;
    idx_d = '0;
    for (int r = 0; r < READ; r++) begin
      for (int e = 0; e < DEPTH; e++)
        hit[r][e] = srch_valid[e] & bus.enable_i[r][e] &
                    ~|((srch_mem[e] ^ bus.read_data_i[r]) & bus.read_mask_i[r]);
      match_d[r] = bus.read_i[r] & |hit[r];
      multi_d[r] = bus.read_i[r] & ((hit[r] & (hit[r] - DEPTH'(1))) != '0);
      for (int i = DEPTH - 1; i >= 0; i--) begin
        logic [ADDRESS-1:0] s;
        s = PRIORITY_EN[r] ? bus.head_i + ADDRESS'(i) : ADDRESS'(i);
        if (bus.read_i[r] && hit[r][s]) idx_d[r] = s;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      count_q <= '0;
      match_q <= '0;
      multi_q <= '0;
      idx_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      match_q <= match_d;
      multi_q <= multi_d;
      idx_q <= idx_d;
    end
  end
  always_ff @(posedge clk)
    if (rst_n) mem_q <= mem_d;
  assign bus.match_o = match_q;
  assign bus.match_data_o = idx_q;
  assign bus.multi_match_o = multi_q;
  assign bus.count_o = count_q;
  assign bus.full_o = count_q == CW'(DEPTH);
endmodule

// File: doc/vlsu_cam_prio.md
Name: vlsu_cam_prio

Overview:
Parametrised multi-port CAM for the VLSU, next generation of vlsu_cam_top. It adds:
- N write ports, M search ports and per-entry valid bits.
- A clear port and per-port search masks.
- Head-relative oldest-first priority and optional same-cycle write-to-search bypass.
- Registered match outputs and occupancy tracking.
It sits between the load/store queue allocation logic (writes/clears) and the address-disambiguation search ports.

Parameters:
WIDTH, 50, stored/search data width
DEPTH, 32, number of entries (power of two, >=2)
WRITE, 2, number of write ports
READ, 3, number of search ports
ADDRESS, $clog2(DEPTH), entry index width
PRIORITY_EN, 3'b111, per-search-port bit: 1 = oldest-first from head_i, 0 = lowest index first
BYPASS, 1, 1 = searches see same-cycle writes/clears; 0 = searches see pre-edge contents

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
head_i  in  ADDRESS  oldest entry index for priority
enable_i  in  READ x DEPTH  per-port entry compare enable
write_i  in  WRITE  write strobe per port
write_addr_i  in  WRITE x ADDRESS  write entry index
write_data_i  in  WRITE x WIDTH  write data
clear_i  in  1  invalidate strobe
clear_addr_i  in  ADDRESS  entry to invalidate
read_i  in  READ  search strobe per port
read_data_i  in  READ x WIDTH  search key
read_mask_i  in  READ x WIDTH  1 = bit compared, 0 = don't care
match_o  out  READ  registered hit flag
match_data_o  out  READ x ADDRESS  registered index of selected hit
multi_match_o  out  READ  registered: more than one entry hit
count_o  out  $clog2(DEPTH+1)  number of valid entries
full_o  out  1  count_o == DEPTH

Behaviour:
- Reset (rst_n=0 at posedge): all valid bits 0, match_o/match_data_o/multi_match_o/count_o/full_o = 0. Data array not reset. Write/clear/search inputs ignored in that cycle. Reset mid-operation discards in-flight search results; outputs read 0 the next cycle.
- Write: at posedge with write_i[w], entry write_addr_i[w] <= write_data_i[w], valid <= 1.
  - Two ports on the same address: highest port index wins.
  - Rewriting an already-valid entry does not change count_o.
- Clear: at posedge with clear_i, valid[clear_addr_i] <= 0.
  - Write and clear to the same address in the same cycle: write wins, entry ends valid.
- Hit vector, port r: hit[e] = valid[e] & enable_i[r][e] & ((entry[e] ^ read_data_i[r]) & read_mask_i[r]) == 0.
  - BYPASS=1: valid/entry are the post-edge (next-state) values, so a same-cycle write is found and a same-cycle clear is not.
  - BYPASS=0: current register values.
- Selection:
  - PRIORITY_EN[r]=1: first hit scanning head_i, head_i+1, …, wrapping modulo DEPTH to head_i-1.
  - PRIORITY_EN[r]=0: lowest hit index.
- Outputs: latency 1. Search presented in cycle N is visible after posedge N+1.
  - match_o[r] = read_i[r] & |hit.
  - match_data_o[r] = selected index, or 0 when no hit or read_i[r]=0.
  - multi_match_o[r] = read_i[r] & popcount(hit) >= 2.
- Mask all zeros: every valid, enabled entry hits.
- count_o: registered, updated each posedge by the number of entries whose valid changes 0->1 minus those changing 1->0. count_o never exceeds DEPTH or goes below 0; this follows from counting actual transitions.
- full_o: combinational from count_o.

Test Plan:
- Reset then idle: rst_n=0 two cycles -> all outputs 0; search key 0, mask all-ones, read_i=3'b111 -> match_o=3'b000 (no valid entries despite stale data).
- Write-then-search, BYPASS=0: write port0 addr k data k+1 for k=0..31 with a search of k+1 on all ports in the next cycle -> match_o=3'b111, match_data_o=k one cycle after the search; count_o steps 1..32 and full_o=1 after the last write.
- Same-cycle bypass, BYPASS=1: write addr 5 data 0x3FF and search 0x3FF in the same cycle -> match_o[0]=1, match_data_o[0]=5 next cycle. With BYPASS=0 the same stimulus gives match_o[0]=0.
- Head priority: data 0x7 in entries 2, 9, 20, head_i=10 -> port0 (PRIORITY_EN=1) reports 20 with multi_match_o=1; head_i=21 -> reports 2; port with PRIORITY_EN=0 reports 2.
- Write port conflict and clear collisions:
  - write_i=2'b11, both ports to addr 3 with data 0xA/0xB -> entry 3 holds 0xB.
  - clear_i plus write to addr 3 in the same cycle -> entry stays valid, count_o unchanged.
  - clear of addr 3 alone -> count_o decrements by 1, later searches of 0xB miss.
- Masked search with enable gating: entry 4=0x1F0, key 0x100, mask 0x00F -> hit; enable_i[1][4]=0 -> match_o[1]=0 while match_o[0]=1. Assert rst_n=0 in the cycle after the search -> outputs 0.
